// File: rtl/pipelined_adder_if.sv
// Operand/result bus of the pipelined adder. The master drives the operands and
// enable; the slave (the adder) returns the registered sum.
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  // enable is the only flow control: every register advances on an edge with
  // enable=1 and holds otherwise. i_valid / o_valid only tag beats and do not
  // throttle anything (no back-pressure).
  logic             enable;
  logic             i_valid;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
  logic [WIDTH-1:0] o_s;
  logic             o_cout;
  logic             o_valid;

  modport master (
    output enable, i_valid, i_a, i_b, i_cin,
    input  o_s, o_cout, o_valid
  );

  modport slave (
    input  enable, i_valid, i_a, i_b, i_cin,
    output o_s, o_cout, o_valid
  );
endinterface

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder with the carry chain cut into STAGES equal chunks. Operands are
// skewed in, partial sums deskewed out; one addition per enabled clock.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              reset,
  pipelined_adder_if.slave  bus
);
  localparam int C = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > 8 || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_adder: illegal WIDTH/STAGES combination");
  end

  logic [STAGES-1:0] carry_w;
  logic [WIDTH-1:0]  sum_w;
  logic [STAGES-1:0] vld_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int D = STAGES - 1 - k;

    logic [C-1:0] a_in;
    logic [C-1:0] b_in;
    logic         c_in;
    logic [C:0]   sum_d;
    logic [C-1:0] psum_q;
    logic         cout_q;

    if (k == 0) begin : g_direct
      assign a_in = bus.i_a[C-1:0];
      assign b_in = bus.i_b[C-1:0];
      assign c_in = bus.i_cin;
    end else begin : g_skew
      // Chunk k waits k levels so it meets the carry produced by chunk k-1.
      logic [k-1:0][C-1:0] a_sk_q;
      logic [k-1:0][C-1:0] b_sk_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          a_sk_q <= '0;
          b_sk_q <= '0;
        end else if (bus.enable) begin
          a_sk_q[0] <= bus.i_a[k*C +: C];
          b_sk_q[0] <= bus.i_b[k*C +: C];
          for (int j = 1; j < k; j++) begin
            a_sk_q[j] <= a_sk_q[j-1];
            b_sk_q[j] <= b_sk_q[j-1];
          end
        end
      end

      assign a_in = a_sk_q[k-1];
      assign b_in = b_sk_q[k-1];
      assign c_in = carry_w[k-1];
    end

    assign sum_d = {1'b0, a_in} + {1'b0, b_in} + {{C{1'b0}}, c_in};

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        psum_q <= '0;
        cout_q <= 1'b0;
      end else if (bus.enable) begin
        psum_q <= sum_d[C-1:0];
        cout_q <= sum_d[C];
      end
    end

    assign carry_w[k] = cout_q;

    if (D == 0) begin : g_no_deskew
      assign sum_w[k*C +: C] = psum_q;
    end else begin : g_deskew
      // Early chunks wait for the last chunk so the whole sum leaves together.
      logic [D-1:0][C-1:0] ds_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          ds_q <= '0;
        end else if (bus.enable) begin
          ds_q[0] <= psum_q;
          for (int j = 1; j < D; j++) begin
            ds_q[j] <= ds_q[j-1];
          end
        end
      end

      assign sum_w[k*C +: C] = ds_q[D-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
    end else if (bus.enable) begin
      vld_q[0] <= bus.i_valid;
      for (int j = 1; j < STAGES; j++) begin
        vld_q[j] <= vld_q[j-1];
      end
    end
  end

  assign bus.o_s     = sum_w;
  assign bus.o_cout  = carry_w[STAGES-1];
  assign bus.o_valid = vld_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: four instances (STAGES 4, 1, 2, 8) share one stimulus
// stream; a per-instance expected queue models latency, stalls and reset.
module tb_pipelined_adder;
  localparam int W  = 32;
  localparam int ND = 4;

  function automatic int st_of(int g);
    case (g)
      0:       return 4;
      1:       return 1;
      2:       return 2;
      default: return 8;
    endcase
  endfunction

  // clock / reset
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // shared drive and per-instance observation
  logic         en_drv;
  logic         v_drv;
  logic [W-1:0] a_drv;
  logic [W-1:0] b_drv;
  logic         cin_drv;

  logic [W-1:0] obs_s [ND];
  logic         obs_c [ND];
  logic         obs_v [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    pipelined_adder_if #(.WIDTH(W)) bus ();

    assign bus.enable  = en_drv;
    assign bus.i_valid = v_drv;
    assign bus.i_a     = a_drv;
    assign bus.i_b     = b_drv;
    assign bus.i_cin   = cin_drv;
    assign obs_s[g]    = bus.o_s;
    assign obs_c[g]    = bus.o_cout;
    assign obs_v[g]    = bus.o_valid;

    pipelined_adder #(.WIDTH(W), .STAGES(st_of(g))) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
    );
  end

  // scoreboard: entry = {valid, cout, sum}, one push per enabled edge
  logic [W+1:0] exp_q [ND][$];
  logic [W+1:0] cur_exp [ND];
  bit           known [ND];
  int           total;
  int           bad;
  logic [W-1:0] lfsr;

  task automatic chk(string tag, int d, logic [W-1:0] obs, logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s stages=%0d observed=%h expected=%h", tag, st_of(d), obs, exp);
    end
  endtask

  task automatic chk_outputs(int d, logic [W+1:0] e);
    chk("o_valid", d, {31'b0, obs_v[d]}, {31'b0, e[W+1]});
    chk("o_cout",  d, {31'b0, obs_c[d]}, {31'b0, e[W]});
    chk("o_s",     d, obs_s[d], e[W-1:0]);
  endtask

  task automatic step(bit en, bit v, logic [W-1:0] a, logic [W-1:0] b, bit cin);
    logic [W:0]   sum;
    logic [W+1:0] e;
    en_drv  = en;
    v_drv   = v;
    a_drv   = a;
    b_drv   = b;
    cin_drv = cin;
    sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      if (en) begin
        exp_q[d].push_back({v, sum});
        if (exp_q[d].size() == st_of(d)) begin
          e = exp_q[d].pop_front();
          cur_exp[d] = e;
          known[d]   = 1'b1;
          chk_outputs(d, e);
        end else begin
          known[d] = 1'b0;
          chk("o_valid_fill", d, {31'b0, obs_v[d]}, '0);
        end
      end else if (known[d]) begin
        chk_outputs(d, cur_exp[d]);
      end else begin
        chk("o_valid_stall_fill", d, {31'b0, obs_v[d]}, '0);
      end
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  // Asserts reset between edges with live inputs; outputs must clear at once.
  task automatic apply_reset();
    en_drv  = 1'b1;
    v_drv   = 1'b1;
    a_drv   = $urandom;
    b_drv   = $urandom;
    cin_drv = 1'($urandom_range(0, 1));
    reset   = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      exp_q[d].delete();
      known[d] = 1'b0;
      chk_outputs(d, '0);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      chk_outputs(d, '0);
    end
    reset = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int d = 0; d < ND; d++) begin
      known[d]   = 1'b0;
      cur_exp[d] = '0;
    end

    // reset with random operands, then idle edges must not raise o_valid
    apply_reset();
    idle(4);

    // single beat latency
    step(1'b1, 1'b1, 32'h0000_0003, 32'h0000_0004, 1'b0);
    idle(8);

    // carry through every chunk boundary
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    step(1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    idle(8);

    // back-to-back LFSR stream
    lfsr = 32'hACE1_1234;
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      lfsr = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
      a    = lfsr;
      lfsr = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
      b    = lfsr;
      step(1'b1, 1'b1, a, b, 1'($urandom_range(0, 1)));
    end
    idle(8);

    // stall three cycles while beat 2 sits in stage 1
    step(1'b1, 1'b1, 32'h1111_1111, 32'h0000_0001, 1'b0);
    step(1'b1, 1'b1, 32'h2222_2222, 32'h0000_0002, 1'b0);
    step(1'b1, 1'b1, 32'h3333_3333, 32'h0000_0003, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, $urandom, $urandom, 1'b1);
    end
    idle(8);

    // reset with three beats in flight; none may ever emerge
    step(1'b1, 1'b1, 32'hDEAD_0000, 32'h0000_BEEF, 1'b0);
    step(1'b1, 1'b1, 32'hCAFE_0000, 32'h0000_F00D, 1'b1);
    step(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    apply_reset();
    idle(9);

    // stream after reset recovery
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

- Pipelined WIDTH-bit adder that serves as the device under test on the testbench DUT conduit.
- Consumes the driven operands `dut_a`/`dut_b` and returns the sum on `dut_s` for the monitor.
- The carry chain is split into STAGES equal chunks, one pipeline register level per chunk.
- Sustains one addition per clock, with a fixed latency the monitor compensates for.

## Interface

Parameters:
- WIDTH, 32, operand and sum width.
- STAGES, 4, number of pipeline stages; legal 1..8; WIDTH % STAGES must be 0; chunk width C = WIDTH/STAGES.

Ports:
- clk  input  1  sole clock (the DUT clock domain).
- reset  input  1  asynchronous, active-low reset; clears every register immediately on assertion.
- enable  input  1  pipeline advance; when 0 every register holds its value.
- i_valid  input  1  marks i_a/i_b/i_cin as a real operand pair.
- i_a  input  WIDTH  operand A.
- i_b  input  WIDTH  operand B.
- i_cin  input  1  carry-in to bit 0.
- o_s  output  WIDTH  sum, modulo 2^WIDTH.
- o_cout  output  1  carry-out of bit WIDTH-1.
- o_valid  output  1  i_valid delayed by the pipeline, aligned with o_s.

## Operation

- All outputs are registered; reset value of o_s, o_cout and o_valid is 0.
- All internal skew, partial-sum and carry registers also reset to 0.

Stage k (k = 0..STAGES-1), on each enabled edge:
- Adds chunk k of A and B (bits k·C .. k·C+C-1) plus the carry registered by stage k-1.
- For stage 0 the carry input is i_cin.
- Registers the C-bit partial sum and the chunk carry.

Operand and result alignment:
- Operand skew: chunk k of A and B is delayed k register levels before entering stage k, so all chunks of one operand pair see their correct carry.
- Result deskew: the partial sum of stage k is delayed STAGES-1-k further levels, so all chunks of one result emerge on the same cycle.
- o_cout is the carry registered by stage STAGES-1.

Valid pipeline:
- i_valid travels through a STAGES-deep shift register that advances with enable.
- o_s/o_cout are computed regardless of valid; o_valid only qualifies them.

Stall (enable=0):
- Every register holds, including the valid pipeline.
- Input values presented during the stall are ignored.
- No beat is lost or duplicated.

Reset asserted mid-operation:
- All in-flight results are discarded; outputs read 0 immediately (asynchronously).
- After release, o_valid stays 0 until a new valid beat has traversed all STAGES levels.

Arithmetic:
- Unsigned addition; {o_cout, o_s} = i_a + i_b + i_cin exactly (WIDTH+1 bits).
- Wrap-around: 0xFFFFFFFF + 1 gives o_s=0, o_cout=1.

Boundary: STAGES=1 degenerates to one registered full-width adder with no skew/deskew registers.

## Timing

- Throughput: one operand pair accepted per enabled clock.
- Latency: operands sampled at enabled edge t appear on o_s/o_cout/o_valid right after the STAGES-th enabled edge counting t as the first (STAGES=4: after edge t+3, with no stalls).
- Stalls stretch the latency by exactly the number of disabled cycles.
- Reset release: the first edge with reset high is a normal enabled edge; there is no reset-recovery cycle.
- Critical path: one C-bit adder plus carry register setup.

## Test plan

- Reset check: assert reset with random i_a/i_b driven, then release. Required: o_s=0, o_cout=0, o_valid=0 during reset; o_valid stays 0 for 4 edges after release with i_valid=0.
- Latency, STAGES=4:
  - Single beat at edge t: a=0x00000003, b=0x00000004, cin=0, i_valid=1.
  - Required: o_s=0x00000007, o_valid=1 exactly after edge t+3, and o_valid=0 on the cycles before and after.
- Carry across every chunk boundary: a=0xFFFFFFFF, b=0x00000001, cin=0.
  - Required: o_s=0x00000000, o_cout=1.
  - Then a=0x7FFFFFFF, b=0x00000000, cin=1. Required: o_s=0x80000000, o_cout=0.
- Back-to-back stream: 1000 consecutive LFSR pairs, one per edge. Required: every o_s/o_cout matches the 33-bit reference sum, in order, with o_valid high on every cycle once the pipe fills.
- Stall: stream beats 1,2,3; drop enable for 3 cycles while beat 2 is in stage 1.
  - Required: outputs freeze during the stall.
  - Sequence resumes with no lost or duplicate beat.
  - Beat 2's latency is 4+3 cycles.
- Mid-flight reset and parameter sweep:
  - Assert reset with 3 beats in flight. Required: none of them ever appears on o_valid.
  - Repeat the stream test for STAGES ∈ {1,2,8}. Required: latency equals STAGES.
